// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter / run-control stage.
package pc_pkg;

  localparam int PC_W  = 12;
  localparam int CNT_W = 16;

  // Assembler-facing program entry points, indexed by ProgSel
  localparam int ENTRY0_DEF = 0;
  localparam int ENTRY1_DEF = 150;
  localparam int ENTRY2_DEF = 620;
  localparam int ENTRY3_DEF = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } run_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux used while a program is running:
// halt/stall hold, then absolute jump, then relative branch, then sequential.
module pc_next_sel #(
  parameter int PC_W = 12
) (
  input  logic [PC_W-1:0] pc,
  input  logic            halt,
  input  logic            stall,
  input  logic            branch_abs,
  input  logic [PC_W-1:0] target,
  input  logic            branch_rel,
  input  logic [7:0]      offset,
  output logic [PC_W-1:0] pc_next
);

  logic [PC_W-1:0] offset_ext;

  // Sign-extend the 8-bit relative offset to PC width
  always_comb begin
    offset_ext = {{(PC_W-8){offset[7]}}, offset};
  end

  // Priority select; all arithmetic wraps modulo 2^PC_W
  always_comb begin
    pc_next = pc + PC_W'(1);
    if (halt || stall) begin
      pc_next = pc;
    end else if (branch_abs) begin
      pc_next = target;
    end else if (branch_rel) begin
      pc_next = pc + offset_ext;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and run control: IDLE/RUN/DONE sequencing, entry-point
// selection on Start, and a saturating count of cycles spent in RUN.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int PC_W   = pc_pkg::PC_W,
  parameter int ENTRY0 = pc_pkg::ENTRY0_DEF,
  parameter int ENTRY1 = pc_pkg::ENTRY1_DEF,
  parameter int ENTRY2 = pc_pkg::ENTRY2_DEF,
  parameter int ENTRY3 = pc_pkg::ENTRY3_DEF,
  parameter int CNT_W  = pc_pkg::CNT_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       ProgSel,
  input  logic             Halt,
  input  logic             Stall,
  input  logic             BranchAbs,
  input  logic [PC_W-1:0]  Target,
  input  logic             BranchRel,
  input  logic [7:0]       Offset,
  output logic [PC_W-1:0]  PC,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCount
);

  run_state_t       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d, pc_run, entry_pc;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  pc_next_sel #(.PC_W(PC_W)) u_next_sel (
    .pc         (pc_q),
    .halt       (Halt),
    .stall      (Stall),
    .branch_abs (BranchAbs),
    .target     (Target),
    .branch_rel (BranchRel),
    .offset     (Offset),
    .pc_next    (pc_run)
  );

  // Entry point chosen by ProgSel, used whenever a run is (re)started
  always_comb begin
    case (ProgSel)
      2'd0:    entry_pc = PC_W'(ENTRY0);
      2'd1:    entry_pc = PC_W'(ENTRY1);
      2'd2:    entry_pc = PC_W'(ENTRY2);
      default: entry_pc = PC_W'(ENTRY3);
    endcase
  end

  // Next-state, next-PC and counter update; everything holds by default
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = entry_pc;
          cnt_d   = '0;
        end
      end
      RUN: begin
        pc_d = pc_run;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (Halt) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, PC and counter registers with asynchronous clear
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs come straight from registers so there is no input-to-output path
  always_comb begin
    PC         = pc_q;
    CycleCount = cnt_q;
    Running    = (state_q == RUN);
    Done       = (state_q == DONE);
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [1:0]  ProgSel;
  logic        Halt;
  logic        Stall;
  logic        BranchAbs;
  logic [11:0] Target;
  logic        BranchRel;
  logic [7:0]  Offset;
  logic [11:0] PC;
  logic        Running;
  logic        Done;
  logic [15:0] CycleCount;

  int total = 0;
  int bad   = 0;

  pc_sequencer dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .ProgSel    (ProgSel),
    .Halt       (Halt),
    .Stall      (Stall),
    .BranchAbs  (BranchAbs),
    .Target     (Target),
    .BranchRel  (BranchRel),
    .Offset     (Offset),
    .PC         (PC),
    .Running    (Running),
    .Done       (Done),
    .CycleCount (CycleCount)
  );

  // Free-running clock, 10 time-unit period
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one rising edge and settle 1 unit after it
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_ctrl();
    Start     = 1'b0;
    Halt      = 1'b0;
    Stall     = 1'b0;
    BranchAbs = 1'b0;
    BranchRel = 1'b0;
    Target    = '0;
    Offset    = '0;
  endtask

  task automatic test_reset();
    Reset   = 1'b1;
    ProgSel = 2'd0;
    clear_ctrl();
    #1;
    total++; if (PC !== 12'd0) begin bad++; $display("[TB] FAIL reset_pc got=%0d exp=0", PC); end
    total++; if (Running !== 1'b0) begin bad++; $display("[TB] FAIL reset_running got=%b exp=0", Running); end
    total++; if (Done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b exp=0", Done); end
    total++; if (CycleCount !== 16'd0) begin bad++; $display("[TB] FAIL reset_cnt got=%0d exp=0", CycleCount); end
    step();
    step();
    Reset = 1'b0;
    step();
    total++; if (Running !== 1'b0) begin bad++; $display("[TB] FAIL idle_running got=%b exp=0", Running); end
  endtask

  task automatic test_start_seq();
    Start   = 1'b1;
    ProgSel = 2'd1;
    step();
    Start = 1'b0;
    total++; if (PC !== 12'd150) begin bad++; $display("[TB] FAIL start_pc got=%0d exp=150", PC); end
    total++; if (Running !== 1'b1) begin bad++; $display("[TB] FAIL start_running got=%b exp=1", Running); end
    total++; if (CycleCount !== 16'd0) begin bad++; $display("[TB] FAIL start_cnt got=%0d exp=0", CycleCount); end
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if (PC !== 12'(150 + i)) begin bad++; $display("[TB] FAIL seq_pc%0d got=%0d exp=%0d", i, PC, 150 + i); end
    end
    total++; if (CycleCount !== 16'd3) begin bad++; $display("[TB] FAIL seq_cnt got=%0d exp=3", CycleCount); end
  endtask

  task automatic test_branches();
    BranchAbs = 1'b1; Target = 12'd600;
    step();
    total++; if (PC !== 12'd600) begin bad++; $display("[TB] FAIL abs600 got=%0d exp=600", PC); end
    Target = 12'd751;
    step();
    total++; if (PC !== 12'd751) begin bad++; $display("[TB] FAIL abs751 got=%0d exp=751", PC); end
    Target = 12'd5;
    step();
    BranchAbs = 1'b0; BranchRel = 1'b1; Offset = 8'hF8;
    step();
    total++; if (PC !== 12'd4093) begin bad++; $display("[TB] FAIL rel_neg got=%0d exp=4093", PC); end
    BranchAbs = 1'b1; Target = 12'd4095;
    step();
    total++; if (PC !== 12'd4095) begin bad++; $display("[TB] FAIL abs_over_rel got=%0d exp=4095", PC); end
    BranchAbs = 1'b0; BranchRel = 1'b0;
    step();
    total++; if (PC !== 12'd0) begin bad++; $display("[TB] FAIL wrap got=%0d exp=0", PC); end
    BranchRel = 1'b1; Offset = 8'd100;
    step();
    BranchRel = 1'b0;
    total++; if (PC !== 12'd100) begin bad++; $display("[TB] FAIL rel_pos got=%0d exp=100", PC); end
  endtask

  task automatic test_stall();
    logic [15:0] c0;
    BranchAbs = 1'b1; Target = 12'd10;
    step();
    BranchAbs = 1'b0;
    c0 = CycleCount;
    Stall = 1'b1;
    step();
    step();
    total++; if (PC !== 12'd10) begin bad++; $display("[TB] FAIL stall_pc got=%0d exp=10", PC); end
    total++; if (CycleCount !== c0 + 16'd2) begin bad++; $display("[TB] FAIL stall_cnt got=%0d exp=%0d", CycleCount, c0 + 16'd2); end
    BranchAbs = 1'b1; Target = 12'd77;
    step();
    total++; if (PC !== 12'd10) begin bad++; $display("[TB] FAIL stall_abs got=%0d exp=10", PC); end
    clear_ctrl();
    step();
    total++; if (PC !== 12'd11) begin bad++; $display("[TB] FAIL stall_release got=%0d exp=11", PC); end
  endtask

  task automatic test_halt_restart();
    logic [15:0] c0;
    BranchAbs = 1'b1; Target = 12'd20;
    step();
    Halt = 1'b1; Target = 12'd99;
    step();
    clear_ctrl();
    total++; if (PC !== 12'd20) begin bad++; $display("[TB] FAIL halt_pc got=%0d exp=20", PC); end
    total++; if (Done !== 1'b1) begin bad++; $display("[TB] FAIL halt_done got=%b exp=1", Done); end
    total++; if (Running !== 1'b0) begin bad++; $display("[TB] FAIL halt_running got=%b exp=0", Running); end
    c0 = CycleCount;
    step();
    step();
    total++; if (PC !== 12'd20) begin bad++; $display("[TB] FAIL done_hold_pc got=%0d exp=20", PC); end
    total++; if (CycleCount !== c0) begin bad++; $display("[TB] FAIL done_hold_cnt got=%0d exp=%0d", CycleCount, c0); end
    Start = 1'b1; ProgSel = 2'd2;
    step();
    total++; if (PC !== 12'd620) begin bad++; $display("[TB] FAIL restart_pc got=%0d exp=620", PC); end
    total++; if (CycleCount !== 16'd0) begin bad++; $display("[TB] FAIL restart_cnt got=%0d exp=0", CycleCount); end
    ProgSel = 2'd1;
    step();
    Start = 1'b0;
    total++; if (PC !== 12'd621) begin bad++; $display("[TB] FAIL start_in_run got=%0d exp=621", PC); end
    total++; if (CycleCount !== 16'd1) begin bad++; $display("[TB] FAIL start_in_run_cnt got=%0d exp=1", CycleCount); end
  endtask

  task automatic test_saturate();
    repeat (65540) @(posedge Clk);
    #1;
    total++; if (CycleCount !== 16'd65535) begin bad++; $display("[TB] FAIL sat got=%0d exp=65535", CycleCount); end
    step();
    total++; if (CycleCount !== 16'd65535) begin bad++; $display("[TB] FAIL sat_hold got=%0d exp=65535", CycleCount); end
  endtask

  task automatic test_async_reset();
    BranchAbs = 1'b1; Target = 12'd300;
    #2;
    Reset = 1'b1;
    #1;
    total++; if (PC !== 12'd0) begin bad++; $display("[TB] FAIL arst_pc got=%0d exp=0", PC); end
    total++; if (Running !== 1'b0) begin bad++; $display("[TB] FAIL arst_running got=%b exp=0", Running); end
    total++; if (CycleCount !== 16'd0) begin bad++; $display("[TB] FAIL arst_cnt got=%0d exp=0", CycleCount); end
    step();
    Reset = 1'b0;
    step();
    total++; if (PC !== 12'd0) begin bad++; $display("[TB] FAIL arst_idle_pc got=%0d exp=0", PC); end
    total++; if (Running !== 1'b0) begin bad++; $display("[TB] FAIL arst_idle_state got=%b exp=0", Running); end
    clear_ctrl();
    Start = 1'b1; ProgSel = 2'd3;
    step();
    Start = 1'b0;
    step();
    Halt = 1'b1;
    step();
    Halt = 1'b0;
    total++; if (Done !== 1'b1) begin bad++; $display("[TB] FAIL pre_arst_done got=%b exp=1", Done); end
    total++; if (PC !== 12'd1) begin bad++; $display("[TB] FAIL entry3_pc got=%0d exp=1", PC); end
    #2;
    Reset = 1'b1;
    #1;
    total++; if (Done !== 1'b0) begin bad++; $display("[TB] FAIL arst_done got=%b exp=0", Done); end
    Reset = 1'b0;
  endtask

  // Run each scenario in order and print the summary
  initial begin
    test_reset();
    test_start_seq();
    test_branches();
    test_stall();
    test_halt_restart();
    test_saturate();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and run-control stage that sits directly downstream of the branch-target lookup table: it consumes the 12-bit absolute `Target` from the LUT plus short relative offsets and produces the instruction-memory fetch address every cycle. It also sequences one program run (start, halt, done), selects one of four program entry points and counts executed cycles for the bench.

## Interface
Parameters:
- `PC_W`, 12, program-counter width; matches the LUT target width
- `ENTRY0`, 0, entry address for `ProgSel`=0
- `ENTRY1`, 150, entry address for `ProgSel`=1
- `ENTRY2`, 620, entry address for `ProgSel`=2
- `ENTRY3`, 0, entry address for `ProgSel`=3
- `CNT_W`, 16, cycle-counter width

Ports:
- `Clk`  in  1  single clock; all state updates on the rising edge
- `Reset`  in  1  asynchronous, active-high; clears all state immediately
- `Start`  in  1  begin a run; sampled only in IDLE or DONE
- `ProgSel`  in  2  entry-point select, sampled with `Start`
- `Halt`  in  1  end the run (decoded halt instruction)
- `Stall`  in  1  hold PC this cycle
- `BranchAbs`  in  1  taken absolute jump; next PC = `Target`
- `Target`  in  `PC_W`  absolute target from the LUT
- `BranchRel`  in  1  taken relative branch
- `Offset`  in  8  signed two's-complement relative offset
- `PC`  out  `PC_W`  current fetch address (registered)
- `Running`  out  1  high while in RUN
- `Done`  out  1  high while in DONE
- `CycleCount`  out  `CNT_W`  cycles spent in RUN, saturating

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `Start`=1 -> PC <= entry[`ProgSel`], `CycleCount` <= 0, go RUN. All other inputs ignored.
- RUN, per-cycle priority (highest first):
  - `Halt` -> go DONE; PC holds.
  - `Stall` -> PC holds.
  - `BranchAbs` -> PC <= `Target`.
  - `BranchRel` -> PC <= PC + sign-extend(`Offset`) mod 2^`PC_W`.
  - else PC <= PC + 1 mod 2^`PC_W`.
- `CycleCount` increments on every RUN cycle including stalled and halting cycles; saturates at 2^`CNT_W`-1, never wraps.
- `Start` in RUN is ignored.
- DONE: PC and `CycleCount` hold. `Start`=1 -> PC <= entry[`ProgSel`], `CycleCount` <= 0, go RUN (restart without reset).
- Arithmetic: all PC math in `PC_W` bits; 4095+1 = 0; 5 + (-8) = 4093.

## Timing
- Reset values: PC=0, `Running`=0, `Done`=0, `CycleCount`=0, state IDLE.
- Reset mid-run: outputs return to reset values asynchronously; the next state is IDLE regardless of any in-flight branch or halt.
- Latency: every control input acts on the next rising edge; PC changes one cycle after the qualifying input is sampled. There is no combinational path from inputs to outputs.
- `Running` and `Done` are decoded from the state register and change in the same cycle as the state.
- `Start` edge into RUN: `Running`=1 and PC=entry on the following cycle; the first increment happens one cycle later.
- Simultaneous events:
  - `Halt` + branch -> halt wins and PC holds.
  - `Stall` + branch -> branch is dropped; upstream must re-present it.
  - `BranchAbs` + `BranchRel` -> absolute wins.

## Structure
- Shared package `pc_pkg` holds:
  - the state enum type (IDLE/RUN/DONE)
  - `PC_W` and `CNT_W` constants
  - the default entry constants (0/150/620/0), so the assembler-facing values live in one place
- One natural combinational sub-module: `pc_next_sel`, which takes the current PC, the control bits, `Target` and `Offset` and returns the next PC using the priority mux above.
- The FSM and the saturating counter stay in `pc_sequencer`.

## Test plan
- Reset then `Start`, `ProgSel`=1, no branches for 3 cycles -> PC sequence 150,151,152,153; `Running`=1; `CycleCount`=3.
- RUN at PC=600, `BranchAbs`=1, `Target`=601+150 -> next PC=751. `BranchRel`, `Offset`=-8 at PC=5 -> PC=4093. Increment from 4095 -> 0.
- `Stall` for 2 cycles at PC=10 -> PC stays 10 while `CycleCount` advances by 2. `Stall`+`BranchAbs` together -> PC stays 10.
- `Halt`+`BranchAbs` at PC=20 -> DONE, PC=20, `Done`=1, `Running`=0. `Start`, `ProgSel`=2 -> PC=620, `CycleCount`=0.
- Force `CycleCount` near max with a long run -> holds at 65535. `Reset` asserted mid-branch, between clock edges -> PC=0 and `Done`=0 immediately, state IDLE.
